// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// datapath mux selects and the opcode-class enumeration.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_OPIMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } opc_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_IMMU = 2'b10;
    localparam logic [1:0] SRCB_FOUR = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_opcode_class_dec.sv
// Combinational opcode decoder: instruction class, legality and immediate
// format select. Unknown opcodes report illegal with class R and I-format.
module opcode_class_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opc_class_t op_class,
    output logic       legal,
    output logic [1:0] imm_sel
);

    always_comb begin
        op_class = CLS_R;
        legal    = 1'b1;
        imm_sel  = IMM_I;
        case (opcode)
            OPC_R:      op_class = CLS_R;
            OPC_OPIMM:  op_class = CLS_OPIMM;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE: begin
                op_class = CLS_STORE;
                imm_sel  = IMM_S;
            end
            OPC_BRANCH: begin
                op_class = CLS_BRANCH;
                imm_sel  = IMM_B;
            end
            OPC_JAL: begin
                op_class = CLS_JAL;
                imm_sel  = IMM_J;
            end
            OPC_JALR:   op_class = CLS_JALR;
            OPC_LUI:    op_class = CLS_LUI;
            OPC_AUIPC:  op_class = CLS_AUIPC;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait
// watchdog that traps when MemReady never arrives.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Opcode,
    input  logic       BrTaken,
    input  logic       MemReady,
    output logic [1:0] ImmSel,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcB,
    output logic       ALUSrcA,
    output logic [1:0] ALUOp,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic [1:0] WBSel,
    output logic       Illegal,
    output logic [2:0] State
);

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q;
    opc_class_t cls_q;
    logic [1:0] imm_sel_q;

    opc_class_t dec_cls;
    logic       dec_legal;
    logic [1:0] dec_imm_sel;
    logic       wait_expired;
    logic       ir_we, pc_we, mem_req, mem_we, reg_we;

    opcode_class_dec u_dec (
        .opcode   (Opcode),
        .op_class (dec_cls),
        .legal    (dec_legal),
        .imm_sel  (dec_imm_sel)
    );

    // A coincident MemReady takes priority over the watchdog.
    assign wait_expired = (wait_cnt_q == WAIT_LIM) && !MemReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            cls_q      <= CLS_R;
            imm_sel_q  <= IMM_I;
        end else begin
            state_q <= state_d;
            if (state_d == state_q && (state_q == ST_FETCH || state_q == ST_MEM))
                wait_cnt_q <= wait_cnt_q + 4'd1;
            else
                wait_cnt_q <= '0;
            if (state_q == ST_DECODE) begin
                cls_q     <= dec_cls;
                imm_sel_q <= dec_imm_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ImmSel  = imm_sel_q;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        PCSrc   = PC_PLUS4;
        ALUSrcB = SRCB_RS2;
        ALUSrcA = 1'b0;
        ALUOp   = ALU_ADD;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        IorD    = 1'b0;
        reg_we  = 1'b0;
        WBSel   = WB_ALU;
        Illegal = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // ALU forms PC+4 while the instruction is read.
                mem_req = 1'b1;
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                ImmSel  = dec_imm_sel;
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                state_d = ST_WB;
                case (cls_q)
                    CLS_R:     ALUOp = ALU_FUNCT;
                    CLS_OPIMM: begin
                        ALUOp   = ALU_FUNCT;
                        ALUSrcB = SRCB_IMM;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ALUSrcB = SRCB_IMM;
                        state_d = ST_MEM;
                    end
                    CLS_LUI: begin
                        ALUOp   = ALU_PASSB;
                        ALUSrcB = SRCB_IMMU;
                    end
                    CLS_AUIPC: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = SRCB_IMMU;
                    end
                    CLS_BRANCH: begin
                        ALUOp   = ALU_CMP;
                        pc_we   = BrTaken;
                        PCSrc   = PC_BRANCH;
                        state_d = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_we = 1'b1;
                        PCSrc = PC_BRANCH;
                    end
                    CLS_JALR: begin
                        pc_we   = 1'b1;
                        PCSrc   = PC_ALU;
                        ALUSrcB = SRCB_IMM;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                mem_we  = (cls_q == CLS_STORE);
                if (MemReady)
                    state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                else if (wait_expired)
                    state_d = ST_TRAP;
            end
            ST_WB: begin
                reg_we  = 1'b1;
                state_d = ST_FETCH;
                case (cls_q)
                    CLS_LOAD:          WBSel = WB_MEM;
                    CLS_JAL, CLS_JALR: WBSel = WB_PC4;
                    default:           WBSel = WB_ALU;
                endcase
            end
            ST_TRAP: Illegal = 1'b1;
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset suppresses every enable immediately, even mid-transaction.
    assign IRWrite  = ir_we   & ~rst;
    assign PCWrite  = pc_we   & ~rst;
    assign MemReq   = mem_req & ~rst;
    assign MemWrite = mem_we  & ~rst;
    assign RegWrite = reg_we  & ~rst;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction walks plus a long random run,
// all cycles compared against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam int WAIT_MAX = 15;
    localparam logic [6:0] R_OP  = 7'b0110011, ADDI = 7'b0010011, LW   = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011, BEQ  = 7'b1100011, JAL  = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111, LUI  = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] Opcode = '0;
    logic       BrTaken = 1'b0, MemReady = 1'b0;
    logic [1:0] ImmSel, PCSrc, ALUSrcB, ALUOp, WBSel;
    logic       IRWrite, PCWrite, ALUSrcA, MemReq, MemWrite, IorD, RegWrite, Illegal;
    logic [2:0] State;

    multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .BrTaken(BrTaken), .MemReady(MemReady),
        .ImmSel(ImmSel), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .MemReq(MemReq),
        .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite), .WBSel(WBSel),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_state = 0;
    int         m_cnt = 0;
    logic [6:0] m_op = R_OP;
    bit         m_valid = 1'b0;

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {R_OP, ADDI, LW, SW, BEQ, JAL, JALR, LUI, AUIPC};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == SW)  return 2'd1;
        if (op == BEQ) return 2'd2;
        if (op == JAL) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [20:0] expect_out(input int st, input logic [6:0] op,
                                               input logic [6:0] cur_op, input bit rdy,
                                               input bit br, input bit r);
        logic [1:0] imm = imm_of(op), pcsrc = 2'd0, srcb = 2'd0, aluop = 2'd0, wbsel = 2'd0;
        bit irw = 0, pcw = 0, srca = 0, mreq = 0, mw = 0, iord = 0, rw = 0, ill = 0;
        case (st)
            0: begin mreq = 1; srca = 1; srcb = 2'd3; irw = rdy; pcw = rdy; end
            1: imm = imm_of(cur_op);
            2: begin
                if (op == R_OP)                 aluop = 2'd2;
                if (op == ADDI)                 begin aluop = 2'd2; srcb = 2'd1; end
                if (op == LW || op == SW)       srcb = 2'd1;
                if (op == LUI)                  begin aluop = 2'd3; srcb = 2'd2; end
                if (op == AUIPC)                begin srca = 1; srcb = 2'd2; end
                if (op == BEQ)                  begin aluop = 2'd1; pcw = br; pcsrc = 2'd1; end
                if (op == JAL)                  begin pcw = 1; pcsrc = 2'd1; end
                if (op == JALR)                 begin pcw = 1; pcsrc = 2'd2; srcb = 2'd1; end
            end
            3: begin mreq = 1; iord = 1; mw = (op == SW); end
            4: begin
                rw = 1;
                wbsel = (op == LW) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : 2'd0;
            end
            5: ill = 1;
            default: ;
        endcase
        if (r) begin irw = 0; pcw = 0; mreq = 0; mw = 0; rw = 0; end
        return {3'(st), imm, irw, pcw, pcsrc, srcb, srca, aluop, mreq, mw, iord, rw, wbsel, ill};
    endfunction

    always @(posedge clk) begin
        int ns;
        ns = m_state;
        if (rst) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_op    <= R_OP;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_state)
                0: if (MemReady) ns = 1; else if (m_cnt == WAIT_MAX) ns = 5;
                1: begin m_op <= Opcode; ns = legal_op(Opcode) ? 2 : 5; end
                2: ns = (m_op == BEQ) ? 0 : (m_op == LW || m_op == SW) ? 3 : 4;
                3: if (MemReady) ns = (m_op == LW) ? 4 : 0; else if (m_cnt == WAIT_MAX) ns = 5;
                4: ns = 0;
                default: ns = m_state;
            endcase
            m_state <= ns;
            m_cnt   <= (ns == m_state) ? m_cnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            check("cycle_model",
                  32'({State, ImmSel, IRWrite, PCWrite, PCSrc, ALUSrcB, ALUSrcA, ALUOp,
                       MemReq, MemWrite, IorD, RegWrite, WBSel, Illegal}),
                  32'(expect_out(m_state, m_op, Opcode, MemReady, BrTaken, rst)));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input logic [6:0] op, input bit rdy, input bit br);
        @(posedge clk);
        #1;
        rst = r; Opcode = op; MemReady = rdy; BrTaken = br;
        #1;
    endtask

    logic [6:0] op_tab [12] = '{R_OP, ADDI, LW, SW, BEQ, JAL, JALR, LUI, AUIPC, ADDI, LW, BAD};

    initial begin
        int n;
        bit rw_seen;
        int trap_len, stuck;
        bit r, rdy;

        // reset and release
        cyc(1, R_OP, 1, 0);
        check("rst_state", 32'(State), 0);
        check("rst_enables", 32'({IRWrite, PCWrite, MemReq, MemWrite, RegWrite}), 0);
        check("rst_immsel", 32'(ImmSel), 0);
        cyc(0, ADDI, 1, 0);
        check("release_memreq", 32'(MemReq), 1);
        check("fetch_irwrite", 32'(IRWrite), 1);

        // ADDI: 0,1,2,4,0
        cyc(0, ADDI, 1, 0);
        check("addi_decode", 32'({State, ImmSel, RegWrite}), 32'({3'd1, 2'd0, 1'b0}));
        check("model_addi_decode", 32'(m_state), 1);
        cyc(0, ADDI, 1, 0);
        check("addi_exec", 32'({State, ALUOp, RegWrite}), 32'({3'd2, 2'd2, 1'b0}));
        cyc(0, ADDI, 1, 0);
        check("addi_wb", 32'({State, RegWrite, WBSel}), 32'({3'd4, 1'b1, 2'd0}));
        check("model_addi_wb", 32'(m_state), 4);
        cyc(0, BEQ, 1, 0);
        check("addi_done", 32'({State, RegWrite}), 32'({3'd0, 1'b0}));

        // BEQ taken then not taken in the same EXEC cycle
        cyc(0, BEQ, 1, 1);
        check("beq_immsel", 32'({State, ImmSel}), 32'({3'd1, 2'd2}));
        cyc(0, BEQ, 1, 1);
        check("beq_taken", 32'({State, PCWrite, PCSrc, ALUOp, ImmSel}),
              32'({3'd2, 1'b1, 2'd1, 2'd1, 2'd2}));
        BrTaken = 1'b0;
        #1;
        check("beq_not_taken", 32'(PCWrite), 0);
        cyc(0, SW, 1, 0);
        check("beq_to_fetch", 32'(State), 0);

        // SW with MemReady delayed 3 cycles
        cyc(0, SW, 1, 0);
        check("sw_immsel", 32'({State, ImmSel}), 32'({3'd1, 2'd1}));
        cyc(0, SW, 0, 0);
        check("sw_exec", 32'({State, ALUSrcB}), 32'({3'd2, 2'd1}));
        n = 0;
        rw_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, SW, (i == 3), 0);
            if (State == 3'd3) n++;
            rw_seen |= RegWrite;
            if (i == 0) check("sw_mem_write", 32'({MemReq, MemWrite, IorD}), 32'(3'b111));
        end
        check("sw_mem_cycles", 32'(n), 4);
        cyc(0, BAD, 1, 0);
        rw_seen |= RegWrite;
        check("sw_to_fetch", 32'(State), 0);
        check("sw_no_regwrite", 32'(rw_seen), 0);

        // illegal opcode traps until reset
        cyc(0, BAD, 1, 0);
        check("bad_decode", 32'(State), 1);
        cyc(0, BAD, 1, 0);
        check("bad_trap", 32'({State, Illegal}), 32'({3'd5, 1'b1}));
        for (int i = 0; i < 5; i++) begin
            cyc(0, op_tab[$urandom_range(0, 11)], bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            check("trap_sticky", 32'({State, Illegal, MemReq, PCWrite}), 32'({3'd5, 1'b1, 1'b0, 1'b0}));
        end
        cyc(1, R_OP, 0, 0);
        cyc(0, R_OP, 0, 0);
        check("trap_reset", 32'({State, Illegal, MemReq}), 32'({3'd0, 1'b0, 1'b1}));

        // FETCH watchdog: stuck MemReady traps after the counter hits WAIT_MAX
        n = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(0, R_OP, 0, 0);
            if (State != 3'd0) break;
            n++;
        end
        check("fetch_timeout_cycles", 32'(n), 32'(WAIT_MAX + 1));
        check("fetch_timeout_trap", 32'(State), 5);

        // MemReady arriving on the last allowed cycle wins
        cyc(1, R_OP, 0, 0);
        cyc(0, R_OP, 0, 0);
        for (int i = 1; i < WAIT_MAX; i++) cyc(0, R_OP, 0, 0);
        cyc(0, R_OP, 1, 0);
        check("model_cnt_at_limit", 32'(m_cnt), 32'(WAIT_MAX));
        check("ready_at_limit", 32'({State, IRWrite}), 32'({3'd0, 1'b1}));
        cyc(0, LW, 0, 0);
        check("ready_at_limit_decode", 32'(State), 1);

        // reset mid-MEM of LW
        cyc(0, LW, 0, 0);
        cyc(0, LW, 0, 0);
        check("lw_mem", 32'({State, MemReq, IorD, MemWrite}), 32'({3'd3, 1'b1, 1'b1, 1'b0}));
        cyc(1, LW, 1, 0);
        cyc(1, LW, 0, 0);
        check("lw_rst_state", 32'(State), 0);
        check("lw_rst_enables", 32'({IRWrite, PCWrite, MemReq, MemWrite, RegWrite}), 0);
        cyc(0, LW, 0, 0);
        check("lw_rst_release", 32'({State, MemReq, RegWrite}), 32'({3'd0, 1'b1, 1'b0}));

        // random programs against the model
        trap_len = 0;
        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0) || (trap_len > 3);
            if (stuck > 0) stuck--;
            else if ($urandom_range(0, 299) == 0) stuck = 20;
            rdy = (stuck == 0) && ($urandom_range(0, 9) < 6);
            cyc(r, op_tab[$urandom_range(0, 11)], rdy, bit'($urandom_range(0, 1)));
            trap_len = (m_state == 5) ? trap_len + 1 : 0;
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles spent waiting for MemReady before trapping.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 Opcode  input  7  inst[6:0] from the instruction register.
REQ-005 BrTaken  input  1  branch comparator result, valid in EXEC.
REQ-006 MemReady  input  1  memory completion strobe for the current MemReq.
REQ-007 ImmSel  output  2  immediate-extensor select: 00 I, 01 S, 10 B, 11 J; U-type uses Imm_U and is not selected.
REQ-008 IRWrite  output  1  instruction register load enable.
REQ-009 PCWrite  output  1  PC load enable.
REQ-010 PCSrc  output  2  PC source: 00 PC+4, 01 PC+ImmOut, 10 ALU result (JALR, LSB cleared externally).
REQ-011 ALUSrcB  output  2  ALU operand B: 00 rs2, 01 ImmOut, 10 Imm_U, 11 constant 4.
REQ-012 ALUSrcA  output  1  ALU operand A: 0 rs1, 1 PC.
REQ-013 ALUOp  output  2  00 add, 01 compare/branch, 10 decode by funct fields, 11 pass B.
REQ-014 MemReq, MemWrite, IorD  output  1 each  memory request, write qualifier, address source (0 PC, 1 ALU).
REQ-015 RegWrite  output  1  register-file write enable; WBSel output 2: 00 ALU, 01 memory, 10 PC+4.
REQ-016 Illegal  output  1  sticky flag; high while in TRAP.
REQ-017 State  output  3  current FSM state code, for debug.

Function
REQ-018 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL return to FETCH.
REQ-019 FETCH: MemReq=1, IorD=0, MemWrite=0; on MemReady, IRWrite=1, PCWrite=1, PCSrc=00, next DECODE; otherwise remain, incrementing the wait counter.
REQ-020 DECODE: ImmSel driven from Opcode; no enables asserted; next EXEC for legal opcodes, TRAP otherwise; latency one cycle.
REQ-021 Legal opcodes SHALL be R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-022 ImmSel SHALL be 00 for OP-IMM/LOAD/JALR, 01 for STORE, 10 for BRANCH, 11 for JAL, 00 for all other opcodes, held constant from DECODE through the end of the instruction.
REQ-023 EXEC: R/OP-IMM ALUOp=10; LOAD/STORE ALUOp=00, ALUSrcB=01; LUI ALUOp=11, ALUSrcB=10; AUIPC ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-024 BRANCH in EXEC: ALUOp=01; PCWrite=BrTaken, PCSrc=01; next FETCH (three-cycle instruction when memory is single-cycle).
REQ-025 JAL in EXEC: PCWrite=1, PCSrc=01, next WB with WBSel=10. JALR: PCWrite=1, PCSrc=10, ALUSrcB=01, next WB with WBSel=10.
REQ-026 LOAD/STORE go EXEC->MEM: MemReq=1, IorD=1, MemWrite=1 for STORE only; on MemReady, LOAD goes to WB and STORE goes to FETCH.
REQ-027 WB: RegWrite=1 for exactly one cycle; WBSel 01 for LOAD, 00 for R/OP-IMM/LUI/AUIPC, 10 for JAL/JALR; next FETCH.
REQ-028 PC+4 SHALL be computed in FETCH; the PC value used by branch, jump and AUIPC in EXEC is the fetched PC, tracked externally in an OldPC register written with IRWrite.
REQ-029 Wait counter: 4 bits, cleared on every state entry; when it reaches WAIT_MAX in FETCH or MEM without MemReady, next state is TRAP.
REQ-030 If MemReady coincides with the counter reaching WAIT_MAX, MemReady SHALL win.
REQ-031 TRAP: all enables 0, Illegal=1; exit only by rst.
REQ-032 All enables SHALL be Moore outputs decoded from the state and latched opcode class; PCWrite in BRANCH and the MemReady-qualified enables are the only Mealy terms.

Reset
REQ-033 rst SHALL force State=FETCH, counter=0, Illegal=0, latched class=R, ImmSel=00 and all enables to 0 on the next edge, including when asserted mid-MEM with MemReq outstanding.
REQ-034 On the first cycle after rst deasserts, MemReq SHALL be 1.

Structure
REQ-035 A shared package SHALL hold the state encodings, opcode constants, ImmSel/PCSrc/ALUSrcB/WBSel/ALUOp encodings and the opcode-class enumeration.
REQ-036 One sub-module, opcode_class_dec, SHALL be purely combinational, mapping Opcode to class, legality and ImmSel.

Verification
REQ-037 Verify ADDI (0010011) with MemReady=1: states 0,1,2,4,0; ImmSel=00; RegWrite high only in cycle 4.
REQ-038 Verify BEQ (1100011) with BrTaken=1: ImmSel=10; PCWrite=1 and PCSrc=01 in EXEC; with BrTaken=0, PCWrite=0.
REQ-039 Verify SW with MemReady delayed 3 cycles: MEM held 4 cycles; MemWrite=1; return to FETCH; RegWrite never high.
REQ-040 Verify opcode 1111111: DECODE->TRAP; Illegal=1 held until rst; then FETCH with MemReq=1.
REQ-041 Verify FETCH with MemReady stuck at 0: TRAP after WAIT_MAX=15 cycles; MemReady at cycle 15 proceeds to DECODE instead.
REQ-042 Verify rst asserted mid-MEM of LW: next cycle State=0, all enables 0, no RegWrite.
